shifter_iter: RTL and testbench

Parametrised multi-cycle barrel shifter for the CPU datapath. It supports logical, arithmetic, rotate and signed-amount shifts on a WIDTH-bit operand. The operand is shifted at most STEP bits per clock under a start/busy/done handshake. It sits beside the ALU and trades latency for area on wide operands. The SIGNED mode keeps the legacy encoding: a negative amount is a left shift by its magnitude, and a non-negative amount is an arithmetic right shift.

---
 rtl/shifter_iter.sv | 135 +++++++++++++
 tb/tb_shifter_iter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_iter.sv
// Multi-cycle barrel shifter: shifts a WIDTH-bit operand by at most STEP bits per
// clock under a start/busy/done handshake. Supports SLL, SRL, SRA, ROL, ROR and
// a SIGNED mode (negative amount = left shift by magnitude, else arithmetic right).
module shifter_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [2:0]               mode_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [WIDTH-1:0]         result_o,
    output logic                     err_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // One extra bit so STEP == WIDTH and WIDTH itself are representable.
    localparam logic [SHW:0] StepW  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WidthW = (SHW+1)'(WIDTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;
    typedef enum logic [2:0] {OpSll, OpSrl, OpSra, OpRol, OpRor} op_e;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   rem_q;
    logic             sign_q;
    logic             err_q;

    op_e              op_d;
    logic [SHW-1:0]   amt_eff;
    logic             err_d;
    logic [SHW-1:0]   k;
    logic [SHW:0]     k_inv;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] acc_shift;

    // Decode the requested mode into an internal operation and effective amount.
    always_comb begin
        op_d    = OpSll;
        amt_eff = amt_i;
        err_d   = 1'b0;
        case (mode_i)
            3'd0: op_d = OpSll;
            3'd1: op_d = OpSrl;
            3'd2: op_d = OpSra;
            3'd3: op_d = OpRol;
            3'd4: op_d = OpRor;
            3'd5: begin
                // Negative amount: magnitude (up to 2^(SHW-1)) fits unsigned in SHW bits.
                if (amt_i[SHW-1]) begin
                    op_d    = OpSll;
                    amt_eff = '0 - amt_i;
                end else begin
                    op_d = OpSra;
                end
            end
            default: begin
                err_d   = 1'b1;
                amt_eff = '0;
            end
        endcase
    end

    // Per-cycle partial shift by k = min(rem, STEP).
    always_comb begin
        if ({1'b0, rem_q} > StepW) begin
            k = StepW[SHW-1:0];
        end else begin
            k = rem_q;
        end
        k_inv = WidthW - {1'b0, k};
        // Top k bits set to the latched sign for arithmetic fills.
        fill  = ~({WIDTH{1'b1}} >> k) & {WIDTH{sign_q}};
        case (op_q)
            OpSll:   acc_shift = acc_q << k;
            OpSrl:   acc_shift = acc_q >> k;
            OpSra:   acc_shift = (acc_q >> k) | fill;
            OpRol:   acc_shift = (acc_q << k) | (acc_q >> k_inv);
            OpRor:   acc_shift = (acc_q >> k) | (acc_q << k_inv);
            default: acc_shift = acc_q;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            op_q     <= OpSll;
            acc_q    <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            err_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q   <= data_i;
                        rem_q   <= amt_eff;
                        sign_q  <= data_i[WIDTH-1];
                        err_q   <= err_d;
                        op_q    <= op_d;
                        busy_o  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (rem_q != '0) begin
                        acc_q <= acc_shift;
                        rem_q <= rem_q - k;
                    end else begin
                        result_o <= acc_q;
                        err_o    <= err_q;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_iter.sv
// Self-checking bench for shifter_iter (WIDTH=32, STEP=4) with a reference model
// feeding a scoreboard queue.
module tb_shifter_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic [2:0]        mode_i;
    logic [WIDTH-1:0]  data_i;
    logic [4:0]        amt_i;
    logic              busy_o;
    logic              done_o;
    logic [WIDTH-1:0]  result_o;
    logic              err_o;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    shifter_iter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .data_i   (data_i),
        .amt_i    (amt_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .err_o    (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: full-width shift in one step, latency from the effective amount.
    function automatic exp_t model(input logic [2:0] mode, input logic [31:0] d,
                                   input logic [4:0] a);
        exp_t e;
        int   eff;
        e.err = 1'b0;
        eff   = int'(a);
        case (mode)
            3'd0: e.res = d << a;
            3'd1: e.res = d >> a;
            3'd2: e.res = $signed(d) >>> a;
            3'd3: e.res = (d << a) | (d >> (32 - int'(a)));
            3'd4: e.res = (d >> a) | (d << (32 - int'(a)));
            3'd5: begin
                if (a[4]) begin
                    eff   = 32 - int'(a);
                    e.res = d << eff;
                end else begin
                    e.res = $signed(d) >>> a;
                end
            end
            default: begin
                e.err = 1'b1;
                e.res = d;
                eff   = 0;
            end
        endcase
        e.lat = (eff + 3) / 4 + 1;
        return e;
    endfunction

    // Drive one request; returns #1 after its accept edge with start_i dropped.
    task automatic issue(input logic [2:0] mode, input logic [31:0] d, input logic [4:0] a);
        @(negedge clk_i);
        mode_i  = mode;
        data_i  = d;
        amt_i   = a;
        start_i = 1'b1;
        sb.push_back(model(mode, d, a));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Count edges until done_o, bounded.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 64) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (done_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_i   = 1'b0;
        start_i = 1'b0;
        mode_i  = '0;
        data_i  = '0;
        amt_i   = '0;
        #12;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b result=%h err=%b required all 0",
                     busy_o, done_o, result_o, err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_ops;
        logic [2:0]  tm [0:6] = '{3'd2, 3'd5, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0};
        logic [31:0] td [0:6] = '{32'h8000_0000, 32'h0000_1234, 32'hF000_0000,
                                  32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        logic [4:0]  ta [0:6] = '{5'd5, 5'b10000, 5'b00011, 5'd8, 5'd4, 5'd31, 5'd0};
        int   lat;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            issue(tm[i], td[i], ta[i]);
            checks++;
            if (busy_o !== 1'b1) begin
                failures++;
                $display("FAIL busy_after_accept[%0d]: busy=%b required 1", i, busy_o);
            end
            wait_done(lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL done_timeout[%0d]: no done_o within 64 edges", i);
            end else begin
                if (result_o !== e.res || err_o !== e.err || lat != e.lat || busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL op[%0d]: result=%h err=%b lat=%0d busy=%b required %h %b %0d 0",
                             i, result_o, err_o, lat, busy_o, e.res, e.err, e.lat);
                end
                @(posedge clk_i);
                #1;
                checks++;
                if (done_o !== 1'b0 || result_o !== e.res) begin
                    failures++;
                    $display("FAIL done_pulse[%0d]: done=%b result=%h required 0 %h",
                             i, done_o, result_o, e.res);
                end
            end
        end
    endtask

    task automatic test_illegal;
        int   lat;
        bit   ok;
        exp_t e;
        issue(3'd7, 32'hDEAD_BEEF, 5'd3);
        wait_done(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || result_o !== e.res || err_o !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL illegal_mode: ok=%b result=%h err=%b lat=%0d required 1 %h %b %0d",
                     ok, result_o, err_o, lat, e.res, e.err, e.lat);
        end
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_held: err=%b required 1", err_o);
        end
        issue(3'd0, 32'h0000_0003, 5'd1);
        wait_done(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || result_o !== e.res || err_o !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL err_clear: ok=%b result=%h err=%b lat=%0d required 1 %h %b %0d",
                     ok, result_o, err_o, lat, e.res, e.err, e.lat);
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        bit   ok;
        exp_t e;
        // Zero-amount op; a start pulse arrives while it is busy.
        issue(3'd0, 32'hA5A5_A5A5, 5'd0);
        mode_i  = 3'd1;
        data_i  = 32'h1111_1111;
        amt_i   = 5'd4;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || result_o !== e.res) begin
            failures++;
            $display("FAIL b2b_first: done=%b busy=%b result=%h required 1 0 %h",
                     done_o, busy_o, result_o, e.res);
        end
        // start_i stays high through the done cycle with the next request.
        mode_i = 3'd3;
        data_i = 32'h1234_5678;
        amt_i  = 5'd4;
        sb.push_back(model(3'd3, 32'h1234_5678, 5'd4));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b required 1", busy_o);
        end
        wait_done(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || result_o !== e.res || lat != e.lat) begin
            failures++;
            $display("FAIL b2b_second: ok=%b result=%h lat=%0d required 1 %h %0d",
                     ok, result_o, lat, e.res, e.lat);
        end
        // Long op with an ignored start pulse in the middle.
        issue(3'd1, 32'hFFFF_FFFF, 5'd31);
        #3;
        start_i = 1'b1;
        mode_i  = 3'd0;
        data_i  = 32'h0;
        amt_i   = 5'd0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(lat, ok);
        lat++;
        e = sb.pop_front();
        checks++;
        if (!ok || result_o !== e.res || lat != e.lat) begin
            failures++;
            $display("FAIL busy_ignore: ok=%b result=%h lat=%0d required 1 %h %0d",
                     ok, result_o, lat, e.res, e.lat);
        end
    endtask

    task automatic test_reset_abort;
        int   lat;
        bit   ok;
        bit   seen;
        exp_t e;
        issue(3'd1, 32'hFFFF_FFFF, 5'd31);
        repeat (3) @(posedge clk_i);
        #4;
        rst_i = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: busy=%b done=%b result=%h err=%b required all 0",
                     busy_o, done_o, result_o, err_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_done: activity after aborted op, required none");
        end
        // Request presented together with reset release is taken on the first edge.
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        mode_i  = 3'd4;
        data_i  = 32'h1234_5678;
        amt_i   = 5'd8;
        start_i = 1'b1;
        rst_i   = 1'b1;
        sb.push_back(model(3'd4, 32'h1234_5678, 5'd8));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_accept: busy=%b required 1", busy_o);
        end
        wait_done(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || result_o !== e.res || err_o !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL post_reset_op: ok=%b result=%h err=%b lat=%0d required 1 %h %b %0d",
                     ok, result_o, err_o, lat, e.res, e.err, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
